// File: rtl/avr_io_pkg.sv
// Shared AVR IO-space constants: bus widths, GPIO port B register
// addresses and the register-select encoding used by IO responders.
package avr_io_pkg;

  localparam int IO_AW = 6;
  localparam int IO_DW = 8;

  localparam logic [IO_AW-1:0] PCMSK_ADDR = 6'h15;
  localparam logic [IO_AW-1:0] PINB_ADDR  = 6'h16;
  localparam logic [IO_AW-1:0] DDRB_ADDR  = 6'h17;
  localparam logic [IO_AW-1:0] PORTB_ADDR = 6'h18;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PIN,
    SEL_DDR,
    SEL_PORT,
    SEL_PCMSK
  } io_sel_e;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-bit two-flop synchroniser for asynchronous pad inputs,
// with asynchronous active-high reset.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/avr_gpio_port.sv
// AVR-style GPIO port (PINx/DDRx/PORTx) on the core IO bus.
// Pin-change interrupt and PCMSK are built only with GPIO_PCINT_EN.
module avr_gpio_port
  import avr_io_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [IO_AW-1:0] ADDR_PCMSK = PCMSK_ADDR,
  parameter logic [IO_AW-1:0] ADDR_PIN   = PINB_ADDR,
  parameter logic [IO_AW-1:0] ADDR_DDR   = DDRB_ADDR,
  parameter logic [IO_AW-1:0] ADDR_PORT  = PORTB_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IO_AW-1:0] io_addr,
  input  logic [IO_DW-1:0] io_wdata,
  input  logic             io_wen,
  input  logic             io_ren,
  output logic [IO_DW-1:0] io_rdata,
  output logic             io_rhit,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] ddr_out,
  input  logic [WIDTH-1:0] pin_in,
  output logic             pcint_irq,
  input  logic             pcint_ack
);

  function automatic io_sel_e decode(input logic [IO_AW-1:0] a);
    io_sel_e s;
    s = SEL_NONE;
    unique case (1'b1)
      (a == ADDR_PIN):   s = SEL_PIN;
      (a == ADDR_DDR):   s = SEL_DDR;
      (a == ADDR_PORT):  s = SEL_PORT;
`ifdef GPIO_PCINT_EN
      (a == ADDR_PCMSK): s = SEL_PCMSK;
`endif
      default:           s = SEL_NONE;
    endcase
    return s;
  endfunction

  io_sel_e          sel;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] pcmsk;
  logic [IO_DW-1:0] rd_val;

  assign sel = decode(io_addr);
  assign wd  = io_wdata[WIDTH-1:0];

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin_in),
    .q     (s2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out <= '0;
      ddr_out  <= '0;
    end else if (io_wen) begin
      unique case (sel)
        SEL_PORT: port_out <= wd;
        SEL_DDR:  ddr_out  <= wd;
        SEL_PIN:  port_out <= port_out ^ wd;
        default:  ;
      endcase
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write reads old data
  always_comb begin
    rd_val = '0;
    unique case (sel)
      SEL_PIN:   rd_val[WIDTH-1:0] = s2;
      SEL_DDR:   rd_val[WIDTH-1:0] = ddr_out;
      SEL_PORT:  rd_val[WIDTH-1:0] = port_out;
      SEL_PCMSK: rd_val[WIDTH-1:0] = pcmsk;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_rdata <= '0;
      io_rhit  <= 1'b0;
    end else if (io_ren && sel != SEL_NONE) begin
      io_rdata <= rd_val;
      io_rhit  <= 1'b1;
    end else begin
      io_rdata <= '0;
      io_rhit  <= 1'b0;
    end
  end

`ifdef GPIO_PCINT_EN
  logic [WIDTH-1:0] s3;
  logic             pc_set;

  assign pc_set = |((s2 ^ s3) & pcmsk);

  // A new change outranks a same-cycle acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3        <= '0;
      pcmsk     <= '0;
      pcint_irq <= 1'b0;
    end else begin
      s3        <= s2;
      pcint_irq <= pc_set | (pcint_irq & ~pcint_ack);
      if (io_wen && sel == SEL_PCMSK)
        pcmsk <= wd;
    end
  end
`else
  logic unused_ack;

  assign unused_ack = pcint_ack;
  assign pcmsk      = '0;
  assign pcint_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_avr_gpio_port.sv
// Directed self-checking bench for avr_gpio_port; PCINT cases are
// exercised when GPIO_PCINT_EN is defined, tie-off checked otherwise.
module tb_avr_gpio_port;

  logic       clk;
  logic       reset;
  logic [5:0] io_addr;
  logic [7:0] io_wdata;
  logic       io_wen;
  logic       io_ren;
  logic [7:0] io_rdata;
  logic       io_rhit;
  logic [7:0] port_out;
  logic [7:0] ddr_out;
  logic [7:0] pin_in;
  logic       pcint_irq;
  logic       pcint_ack;

  int errs;
  int checks;

  avr_gpio_port dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_wen    (io_wen),
    .io_ren    (io_ren),
    .io_rdata  (io_rdata),
    .io_rhit   (io_rhit),
    .port_out  (port_out),
    .ddr_out   (ddr_out),
    .pin_in    (pin_in),
    .pcint_irq (pcint_irq),
    .pcint_ack (pcint_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_addr  = a;
    io_wdata = d;
    io_wen   = 1'b1;
    tick();
    io_wen   = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d,
                    output logic h);
    io_addr = a;
    io_ren  = 1'b1;
    tick();
    io_ren  = 1'b0;
    d = io_rdata;
    h = io_rhit;
  endtask

  logic [7:0] rdv;
  logic       rh;

  initial begin
    errs      = 0;
    checks    = 0;
    reset     = 1'b1;
    io_addr   = '0;
    io_wdata  = '0;
    io_wen    = 1'b0;
    io_ren    = 1'b0;
    pin_in    = '0;
    pcint_ack = 1'b0;

    #3;
    chk("rst_port", port_out, 8'h00);
    chk("rst_ddr", ddr_out, 8'h00);
    chk("rst_rdata", io_rdata, 8'h00);
    chk("rst_rhit", io_rhit, 1'b0);
    chk("rst_irq", pcint_irq, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // PORT write then PIN toggle
    wr(6'h18, 8'h0F);
    chk("port_wr", port_out, 8'h0F);
    wr(6'h16, 8'h3C);
    chk("pin_toggle", port_out, 8'h33);
    rd(6'h18, rdv, rh);
    chk("port_rd", rdv, 8'h33);
    chk("port_rhit", rh, 1'b1);
    tick();
    chk("rhit_drop", io_rhit, 1'b0);

    // Same-cycle read and write of DDR
    io_addr  = 6'h17;
    io_wdata = 8'hFF;
    io_wen   = 1'b1;
    io_ren   = 1'b1;
    tick();
    io_wen   = 1'b0;
    io_ren   = 1'b0;
    chk("rw_old", io_rdata, 8'h00);
    chk("rw_hit", io_rhit, 1'b1);
    chk("rw_ddr", ddr_out, 8'hFF);
    rd(6'h17, rdv, rh);
    chk("ddr_rd", rdv, 8'hFF);

    // Input sync: change before edge N, read sampled at N sees old value
    pin_in  = 8'h81;
    io_addr = 6'h16;
    io_ren  = 1'b1;
    tick();
    io_ren  = 1'b0;
    chk("pin_early", io_rdata, 8'h00);
    tick();
    rd(6'h16, rdv, rh);
    chk("pin_sync", rdv, 8'h81);
    chk("pin_hit", rh, 1'b1);

    // Address miss
    wr(6'h19, 8'hFF);
    chk("miss_port", port_out, 8'h33);
    chk("miss_ddr", ddr_out, 8'hFF);
    rd(6'h19, rdv, rh);
    chk("miss_rdata", rdv, 8'h00);
    chk("miss_rhit", rh, 1'b0);

`ifdef GPIO_PCINT_EN
    wr(6'h15, 8'h04);
    rd(6'h15, rdv, rh);
    chk("pcmsk_rd", rdv, 8'h04);
    chk("pcmsk_hit", rh, 1'b1);
    pin_in = 8'h89;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("irq_masked", pcint_irq, 1'b0);
    end
    pin_in = 8'h8D;
    tick();
    chk("irq_n", pcint_irq, 1'b0);
    tick();
    chk("irq_n1", pcint_irq, 1'b0);
    tick();
    chk("irq_n2", pcint_irq, 1'b1);
    pin_in = 8'h89;
    tick();
    tick();
    chk("irq_hold", pcint_irq, 1'b1);
    pcint_ack = 1'b1;
    tick();
    pcint_ack = 1'b0;
    chk("irq_set_wins", pcint_irq, 1'b1);
    tick();
    pcint_ack = 1'b1;
    tick();
    pcint_ack = 1'b0;
    chk("irq_ack", pcint_irq, 1'b0);
    tick();
    chk("irq_stays_clr", pcint_irq, 1'b0);
`else
    wr(6'h15, 8'hFF);
    rd(6'h15, rdv, rh);
    chk("pcmsk_nohit", rh, 1'b0);
    chk("pcmsk_nodata", rdv, 8'h00);
    pin_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("irq_tied", pcint_irq, 1'b0);
    end
`endif

    // Mid-run asynchronous reset drops the in-flight read
    wr(6'h18, 8'hA5);
    chk("port_a5", port_out, 8'hA5);
    io_addr = 6'h18;
    io_ren  = 1'b1;
    tick();
    io_ren  = 1'b0;
    chk("pre_rst_hit", io_rhit, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_port", port_out, 8'h00);
    chk("async_ddr", ddr_out, 8'h00);
    chk("async_rhit", io_rhit, 1'b0);
    chk("async_rdata", io_rdata, 8'h00);
    chk("async_irq", pcint_irq, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/avr_gpio_port.md
# avr_gpio_port

IO-space responder implementing one AVR-style GPIO port (PINx/DDRx/PORTx) inside avr_soc. Sits on the core's IO bus. Drives port_b/ddr_b toward the pads and samples pin_b from the pads. It is the SoC-side end of the pins that the top-level bench drives and observes. Includes input synchronisation, AVR PIN-write toggle semantics and an optional pin-change interrupt.

## Interface
- WIDTH, 8, port width in bits
- ADDR_PCMSK, 6'h15, IO address of the pin-change mask register (PCINT builds only)
- ADDR_PIN, 6'h16, IO address of PINx
- ADDR_DDR, 6'h17, IO address of DDRx
- ADDR_PORT, 6'h18, IO address of PORTx

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- io_addr  in  6  IO-space address
- io_wdata  in  8  write data
- io_wen  in  1  write strobe, one cycle per write
- io_ren  in  1  read strobe, one cycle per read
- io_rdata  out  8  registered read data
- io_rhit  out  1  high the cycle after io_ren hits one of this port's addresses
- port_out  out  WIDTH  PORTx register (to pads, top-level port_b)
- ddr_out  out  WIDTH  DDRx register (top-level ddr_b)
- pin_in  in  WIDTH  asynchronous pad inputs (top-level pin_b)
- pcint_irq  out  1  pin-change interrupt request
- pcint_ack  in  1  core acknowledge; clears pcint_irq

## Operation
- Reset: port_out=0, ddr_out=0, io_rdata=0, io_rhit=0, pcint_irq=0, PCMSK=0, synchroniser flops=0.
- Write, io_wen=1 and address match:
  - PORT: port_out <= io_wdata.
  - DDR: ddr_out <= io_wdata.
  - PIN: port_out <= port_out ^ io_wdata (AVR toggle; PIN itself is not writable).
  - PCMSK: mask <= io_wdata.
  - Non-matching addresses are ignored.
- Read, io_ren=1 and address match: on the next edge io_rdata <= register value and io_rhit <= 1.
  - PIN returns the synchronised pin value.
  - Non-matching reads set io_rhit=0 and io_rdata=0.
- Simultaneous read and write to the same address in one cycle: the read returns the pre-write value.
- io_wen and io_ren are never both high for different addresses. If they are, both are serviced independently.
- pin_in passes through a 2-flop synchroniser (s1, s2) plus one history flop (s3).
- Pin-change: pcint_irq sets when |((s2 ^ s3) & PCMSK).
  - Cleared by pcint_ack.
  - Set and ack in the same cycle: set wins (irq stays 1).
- Bits above WIDTH in io_wdata are ignored. Read-back of those bits returns 0.
- Reset asserted mid-operation: all state clears immediately, asynchronously. Any in-flight read response is dropped (io_rhit=0).

## Timing
- Write visible on port_out/ddr_out at the first edge after io_wen.
- Read latency 1 cycle: io_rdata/io_rhit valid after the edge following io_ren, held for 1 cycle, then io_rhit=0.
- pin_in change before edge N:
  - N: captured in s1.
  - N+1: captured in s2; a PIN read issued in the cycle after N+1 returns it.
  - N+2: pcint_irq=1.
- Back-to-back reads and writes every cycle are supported with no stall.

## Configuration
- GPIO_PCINT_EN defined: PCMSK register, s3 history flop and pcint_irq logic are built. ADDR_PCMSK is decoded.
- GPIO_PCINT_EN undefined:
  - pcint_irq is tied 0 and pcint_ack is ignored.
  - ADDR_PCMSK is not decoded: writes are ignored, reads give io_rhit=0.

## Structure
- Shared package avr_io_pkg:
  - IO address constants for PINB/DDRB/PORTB/PCMSK.
  - IO bus width constants (address 6, data 8).
- One sub-module, gpio_sync: parameterised WIDTH-bit 2-flop synchroniser with async reset. Reusable for other ports.

## Test plan
- Reset check: assert reset mid-run after writing PORT=0xA5 -> port_out=0x00, ddr_out=0x00, io_rhit=0 immediately, without waiting for a clock edge.
- PORT then PIN toggle: write PORT=0x0F, then write PIN=0x3C -> port_out=0x33. A PORT read returns 0x33 with io_rhit=1 one cycle after io_ren.
- Input sync: pin_in 0x00->0x81 before edge N -> a PIN read issued in the cycle after N+1 returns 0x81. A PIN read issued at N returns 0x00.
- Same-cycle read and write of DDR (old 0x00, new 0xFF) -> io_rdata=0x00, ddr_out=0xFF after the edge. The next read returns 0xFF.
- PCINT (GPIO_PCINT_EN): PCMSK=0x04.
  - Toggle pin_in bit 3 -> no irq.
  - Toggle bit 2 -> pcint_irq=1 two edges after capture.
  - pcint_ack alone -> irq=0.
  - Bit-2 toggle coinciding with ack -> irq stays 1.
- Address miss: write 0xFF to 0x19 and read 0x19 -> no register changes, io_rhit=0, io_rdata=0x00.
